// File: rtl/seg_scan_if.sv
// seg_scan_if: display-scan signal bundle.
// The master side drives the digit/blink/decimal-point requests.
// The slave side (the scanner) drives the anode, segment and frame outputs.
interface seg_scan_if;
  logic [15:0] digits;
  logic [3:0]  blinking;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;

  modport master (
    output digits, blinking, dp,
    input  an, seg, dp_n, frame_start
  );

  modport slave (
    input  digits, blinking, dp,
    output an, seg, dp_n, frame_start
  );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment scanner.
// Each digit is driven for SCAN_DIV cycles. All anodes are off for BLANK_CYCLES
// cycles between digits so that the previous digit does not ghost onto the next.
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan #(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input logic        clk,
  input logic        reset,
  seg_scan_if.slave  bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpn_q, dpn_d;
  logic             fs_q, fs_d;

  logic [3:0]       nibble;
  logic             suppress;
  logic             blankDigit;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexDecode(input logic [3:0] n);
    case (n)
      4'h0:    hexDecode = 7'b1000000;
      4'h1:    hexDecode = 7'b1111001;
      4'h2:    hexDecode = 7'b0100100;
      4'h3:    hexDecode = 7'b0110000;
      4'h4:    hexDecode = 7'b0011001;
      4'h5:    hexDecode = 7'b0010010;
      4'h6:    hexDecode = 7'b0000010;
      4'h7:    hexDecode = 7'b1111000;
      4'h8:    hexDecode = 7'b0000000;
      4'h9:    hexDecode = 7'b0010000;
      4'hA:    hexDecode = 7'b0001000;
      4'hB:    hexDecode = 7'b0000011;
      4'hC:    hexDecode = 7'b1000110;
      4'hD:    hexDecode = 7'b0100001;
      4'hE:    hexDecode = 7'b0000110;
      default: hexDecode = 7'b0001110;
    endcase
  endfunction

  assign nibble = bus.digits[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero detect: a digit is suppressed when it and every higher nibble are zero,
  // unless its decimal point is requested; digit 0 is always shown.
  always_comb begin
    suppress = 1'b0;
    case (idx_q)
      2'd3:    suppress = (bus.digits[15:12] == 4'h0);
      2'd2:    suppress = (bus.digits[15:8]  == 8'h00);
      2'd1:    suppress = (bus.digits[15:4]  == 12'h000);
      default: suppress = 1'b0;
    endcase
    if (bus.dp[idx_q]) suppress = 1'b0;
  end
`else
  assign suppress = 1'b0;
`endif

  assign blankDigit = bus.blinking[idx_q] | suppress;

  // State, counter, digit index and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK;
      cnt_q   <= BLANK_LOAD;
      idx_q   <= 2'd0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dpn_q   <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      fs_q    <= fs_d;
    end
  end

  // Next state; the digit's segments are captured only on BLANK->DRIVE and held for the phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dpn_d   = dpn_q;
    fs_d    = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = SCAN_LOAD;
          an_d    = ~(4'b0001 << idx_q);
          seg_d   = blankDigit ? 7'h7F : hexDecode(nibble);
          dpn_d   = blankDigit | ~bus.dp[idx_q];
          fs_d    = (idx_q == 2'd0);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
          idx_d   = idx_q + 2'd1;
          an_d    = 4'hF;
          seg_d   = 7'h7F;
          dpn_d   = 1'b1;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = BLANK_LOAD;
      end
    endcase
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_n        = dpn_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed scoreboard bench for seg_scan (SCAN_DIV=8, BLANK_CYCLES=2).
// Expected digit phases are pushed when stimulus is driven and popped as each DRIVE phase starts.
// Build with SEG_SCAN_LZB_EN defined to exercise leading-zero blanking.
module tb_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       fs;
  } exp_t;

  logic clk;
  logic reset;
  int   cycleCount;
  int   compared;
  int   mismatched;
  exp_t sb[$];
  int   fsCycles[$];

  seg_scan_if bus ();

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to time frame_start pulses
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference model of one digit phase from the spec's decode table and blanking rules
  function automatic exp_t modelDigit(input int i, input logic [15:0] d,
                                      input logic [3:0] b, input logic [3:0] p);
    exp_t       e;
    logic [3:0] n;
    logic       blank;
`ifdef SEG_SCAN_LZB_EN
    logic [15:0] upper;
`endif
    n     = 4'(d >> (4 * i));
    blank = b[i];
`ifdef SEG_SCAN_LZB_EN
    upper = d >> (4 * i);
    if (i != 0 && upper == 16'h0 && !p[i]) blank = 1'b1;
`endif
    e.an  = ~(4'b0001 << i);
    e.seg = blank ? 7'h7F : SEG_TABLE[n];
    e.dpn = blank ? 1'b1 : ~p[i];
    e.fs  = (i == 0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    bus.digits   = d;
    bus.blinking = b;
    bus.dp       = p;
  endtask

  task automatic pushExpect(input int i, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    sb.push_back(modelDigit(i, d, b, p));
  endtask

  task automatic pushFrame(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    for (int i = 0; i < 4; i++) pushExpect(i, d, b, p);
  endtask

  // Wait out the blank gap, compare the next DRIVE phase against the scoreboard, and
  // follow it to its end; optionally change digits changeAt cycles into the phase.
  task automatic waitPhase(input string tag, input int changeAt, input logic [15:0] newDigits);
    int         gap;
    int         len;
    exp_t       e;
    logic [3:0] a0;
    logic [6:0] s0;
    logic       d0;
    bit         stable;
    bit         fsQuiet;
    bit         oneHot;
    gap     = 0;
    fsQuiet = 1'b1;
    while (bus.an === 4'hF && gap < 100) begin
      if (bus.frame_start !== 1'b0) fsQuiet = 1'b0;
      @(negedge clk);
      gap++;
    end
    checkOutput({tag, ".gap"}, gap, BC);
    if (sb.size() == 0) begin
      checkOutput({tag, ".sbEmpty"}, 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    checkOutput({tag, ".an"},  bus.an,          e.an);
    checkOutput({tag, ".seg"}, bus.seg,         e.seg);
    checkOutput({tag, ".dpn"}, bus.dp_n,        e.dpn);
    checkOutput({tag, ".fs"},  bus.frame_start, e.fs);
    if (bus.frame_start === 1'b1) fsCycles.push_back(cycleCount);
    a0     = bus.an;
    s0     = bus.seg;
    d0     = bus.dp_n;
    len    = 1;
    stable = 1'b1;
    oneHot = ($countones(~bus.an) <= 1);
    while (bus.an === a0 && len < 100) begin
      if (len == changeAt) bus.digits = newDigits;
      @(negedge clk);
      if ($countones(~bus.an) > 1) oneHot = 1'b0;
      if (bus.an === a0) begin
        len++;
        if (bus.seg !== s0 || bus.dp_n !== d0) stable = 1'b0;
        if (bus.frame_start !== 1'b0) fsQuiet = 1'b0;
      end
    end
    checkOutput({tag, ".len"},     len,     SD);
    checkOutput({tag, ".stable"},  stable,  1);
    checkOutput({tag, ".fsQuiet"}, fsQuiet, 1);
    checkOutput({tag, ".oneHot"},  oneHot,  1);
    checkOutput({tag, ".endAn"},   bus.an,  4'hF);
  endtask

  initial begin
    int waits;
    cycleCount = 0;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    applyStimulus(16'h1234, 4'h0, 4'h0);

    // Reset values while held
    repeat (3) @(negedge clk);
    checkOutput("rst.an",  bus.an,          4'hF);
    checkOutput("rst.seg", bus.seg,         7'h7F);
    checkOutput("rst.dpn", bus.dp_n,        1'b1);
    checkOutput("rst.fs",  bus.frame_start, 1'b0);

    // Release: first DRIVE on edge 2, then two full frames of 1234
    reset = 1'b1;
    pushFrame(16'h1234, 4'h0, 4'h0);
    pushFrame(16'h1234, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) waitPhase($sformatf("f1234.%0d", i), 0, 16'h0);
    checkOutput("fsCount", fsCycles.size(), 2);
    if (fsCycles.size() >= 2)
      checkOutput("fsPeriod", fsCycles[1] - fsCycles[0], 4 * (SD + BC));

    // Blink digit 2 of ABCD
    applyStimulus(16'hABCD, 4'b0100, 4'h0);
    pushFrame(16'hABCD, 4'b0100, 4'h0);
    for (int i = 0; i < 4; i++) waitPhase($sformatf("blink.%0d", i), 0, 16'h0);

    // Digits change mid-phase of digit 1; captured value must hold
    applyStimulus(16'h0000, 4'h0, 4'h0);
    pushExpect(0, 16'h0000, 4'h0, 4'h0);
    pushExpect(1, 16'h0000, 4'h0, 4'h0);
    pushExpect(2, 16'h8888, 4'h0, 4'h0);
    pushExpect(3, 16'h8888, 4'h0, 4'h0);
    waitPhase("chg.0", 0, 16'h0);
    waitPhase("chg.1", 4, 16'h8888);
    waitPhase("chg.2", 0, 16'h0);
    waitPhase("chg.3", 0, 16'h0);

    // Asynchronous reset three cycles into digit 0's DRIVE phase
    applyStimulus(16'h1234, 4'h0, 4'h0);
    waits = 0;
    while (bus.an === 4'hF && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("arst.reachDrive", (bus.an !== 4'hF), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst.an",  bus.an,   4'hF);
    checkOutput("arst.seg", bus.seg,  7'h7F);
    checkOutput("arst.dpn", bus.dp_n, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pushFrame(16'h1234, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) waitPhase($sformatf("rerun.%0d", i), 0, 16'h0);

    // Leading zeros, without and with dp on digit 3
    applyStimulus(16'h0050, 4'h0, 4'h0);
    pushFrame(16'h0050, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) waitPhase($sformatf("lz.%0d", i), 0, 16'h0);
    applyStimulus(16'h0050, 4'h0, 4'b1000);
    pushFrame(16'h0050, 4'h0, 4'b1000);
    for (int i = 0; i < 4; i++) waitPhase($sformatf("lzdp.%0d", i), 0, 16'h0);

    checkOutput("sbDrained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
